nvdla_dbb_wr_packer: RTL and testbench
======================================

NVDLA_DBB_WR_PACKER -- requirements
Module: nvdla_dbb_wr_packer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning request address width; legal range 1..32.
REQ-002 SHALL have parameter LEN_WIDTH, default 4, meaning burst-length field width; beats per burst = len+1.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_i  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port clear_i  input  1  meaning synchronous clear, active-high.
REQ-006 SHALL have port enable_i  input  1  meaning permission to accept a new write request.
REQ-007 SHALL have port req_valid_i  input  1  meaning NVDLA DBB write-request valid.
REQ-008 SHALL have port req_ready_o  output  1  meaning write request accepted.
REQ-009 SHALL have port req_addr_i  input  ADDR_WIDTH  meaning burst base address.
REQ-010 SHALL have port req_len_i  input  LEN_WIDTH  meaning beats minus one.
REQ-011 SHALL have port dat_valid_i  input  1  meaning 64-bit write-data beat valid.
REQ-012 SHALL have port dat_ready_o  output  1  meaning write-data beat consumed.
REQ-013 SHALL have port dat_data_i  input  64  meaning write-data beat.
REQ-014 SHALL have ports stream_valid_o output 1, stream_ready_i input 1, stream_data_o output 32, stream_strb_o output 4, meaning the 32-bit hwpe stream feeding the streamer's dbb sink FIFO.
REQ-015 SHALL have ports busy_o output 1 (burst in progress), done_o output 1 (one-cycle burst-complete pulse), frames_o output 16 (completed-burst count).

Function
REQ-016 SHALL implement FSM states IDLE, HDR_ADDR, HDR_LEN, DAT_LO, DAT_HI.
REQ-017 IDLE: req_ready_o = enable_i & ~clear_i; on req_valid_i & req_ready_o, latch addr and len, clear beat counter, go HDR_ADDR.
REQ-018 HDR_ADDR: stream_valid_o=1, stream_data_o = addr zero-extended to 32 bits; on stream_ready_i go HDR_LEN.
REQ-019 HDR_LEN: stream_valid_o=1, stream_data_o = len zero-extended to 32 bits; on stream_ready_i go DAT_LO.
REQ-020 DAT_LO: stream_valid_o = dat_valid_i, stream_data_o = dat_data_i[31:0], dat_ready_o = stream_ready_i; on dat_valid_i & stream_ready_i, register dat_data_i[63:32] and go DAT_HI.
REQ-021 DAT_HI: stream_valid_o=1, stream_data_o = registered high word; on stream_ready_i: if beat counter == len go IDLE and pulse done_o next cycle, else increment counter and go DAT_LO.
REQ-022 dat_ready_o SHALL be 0 in every state except DAT_LO; data beats presented outside DAT_LO are neither consumed nor dropped.
REQ-023 stream_strb_o SHALL be 4'hF whenever stream_valid_o=1, else 4'h0.
REQ-024 In HDR_ADDR, HDR_LEN, DAT_HI, stream_valid_o and stream_data_o SHALL stay stable until stream_ready_i; no state may withdraw valid.
REQ-025 enable_i low SHALL only block new request acceptance in IDLE; an in-progress burst completes.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 frames_o SHALL increment by 1 on each burst completion, wrapping 16'hFFFF -> 16'h0000.
REQ-028 Minimum burst latency: request accept to last stream word = 2 + 2*(len+1) cycles with stream_ready_i and dat_valid_i held high; frame size = 2 + 2*(len+1) words.
REQ-029 clear_i SHALL, on the next edge, force IDLE, zero beat counter, registered high word and frames_o, and deassert done_o; a partial frame is abandoned.
REQ-030 len = 2^LEN_WIDTH-1 SHALL produce exactly 2^LEN_WIDTH beats without counter overflow.

Reset
REQ-031 rst_i high SHALL asynchronously force IDLE, beat counter 0, latched addr/len 0, high-word register 0, frames_o 0.
REQ-032 During reset: req_ready_o=0, dat_ready_o=0, stream_valid_o=0, stream_data_o=0, stream_strb_o=0, busy_o=0, done_o=0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; after release the block accepts a fresh request from IDLE.

Verification
REQ-034 addr=0x1000_0040, len=0, data=0x89AB_CDEF_0123_4567, ready always 1 -> words 0x10000040, 0x00000000, 0x01234567, 0x89ABCDEF; done_o pulse; frames_o=1.
REQ-035 len=3, four beats, stream_ready_i toggling 1/0 each cycle -> 10 words in order, each held stable while ready=0, dat_ready_o high exactly 4 cycles.
REQ-036 enable_i=0 with req_valid_i=1 for 5 cycles -> req_ready_o=0, stream_valid_o=0; enable_i=1 -> accept next cycle.
REQ-037 clear_i pulse in DAT_HI of beat 2 of len=3 -> IDLE next cycle, frames_o=0, no done_o; new len=0 burst then emits 4 correct words.
REQ-038 Preload frames_o to 0xFFFF via 65535 len=0 bursts, one more burst -> frames_o=0x0000.
REQ-039 rst_i asserted asynchronously mid DAT_LO -> all outputs 0 within the same cycle; post-release burst correct.

Source files
------------

// File: rtl/nvdla_dbb_wr_packer_if.sv
// Handshake bundle for the DBB write packer: request, 64-bit data beats and
// the 32-bit hwpe stream toward the streamer's dbb sink FIFO.
interface nvdla_dbb_wr_packer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [LEN_WIDTH-1:0]  req_len_i;

  logic                  dat_valid_i;
  logic                  dat_ready_o;
  logic [63:0]           dat_data_i;

  logic                  stream_valid_o;
  logic                  stream_ready_i;
  logic [31:0]           stream_data_o;
  logic [3:0]            stream_strb_o;

  // packer side
  modport slave (
    input  req_valid_i, req_addr_i, req_len_i,
    input  dat_valid_i, dat_data_i,
    input  stream_ready_i,
    output req_ready_o, dat_ready_o,
    output stream_valid_o, stream_data_o, stream_strb_o
  );

  // requester / stream-sink side
  modport master (
    output req_valid_i, req_addr_i, req_len_i,
    output dat_valid_i, dat_data_i,
    output stream_ready_i,
    input  req_ready_o, dat_ready_o,
    input  stream_valid_o, stream_data_o, stream_strb_o
  );
endinterface

// File: rtl/nvdla_dbb_wr_packer.sv
// DBB write packer: turns one write request plus len+1 64-bit data beats into
// a 32-bit stream frame {addr, len, lo0, hi0, lo1, hi1, ...}.
module nvdla_dbb_wr_packer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        enable_i,
  nvdla_dbb_wr_packer_if.slave        bus,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [15:0]                 frames_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_LEN  = 3'd2,
    DAT_LO   = 3'd3,
    DAT_HI   = 3'd4
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [31:0]           hi_q;
  logic [15:0]           frames_q;
  logic                  done_q;

  // Stream/handshake outputs decoded from the current state. Header and high
  // word come from registers so they hold steady under backpressure; the low
  // word is a pass-through so a beat needs no extra buffering.
  always_comb begin
    bus.req_ready_o    = 1'b0;
    bus.dat_ready_o    = 1'b0;
    bus.stream_valid_o = 1'b0;
    bus.stream_data_o  = 32'h0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = enable_i & ~clear_i & ~rst_i;
      end
      HDR_ADDR: begin
        bus.stream_valid_o = 1'b1;
        bus.stream_data_o  = 32'(addr_q);
      end
      HDR_LEN: begin
        bus.stream_valid_o = 1'b1;
        bus.stream_data_o  = 32'(len_q);
      end
      DAT_LO: begin
        bus.stream_valid_o = bus.dat_valid_i;
        bus.stream_data_o  = bus.dat_data_i[31:0];
        bus.dat_ready_o    = bus.stream_ready_i;
      end
      DAT_HI: begin
        bus.stream_valid_o = 1'b1;
        bus.stream_data_o  = hi_q;
      end
      default: ;
    endcase
    bus.stream_strb_o = bus.stream_valid_o ? 4'hF : 4'h0;
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign frames_o = frames_q;

  // Frame sequencer. The beat counter is compared against len before it is
  // bumped, so len = all-ones finishes on the last counter value with no wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      hi_q     <= 32'h0;
      frames_q <= 16'h0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      hi_q     <= 32'h0;
      frames_q <= 16'h0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i && bus.req_ready_o) begin
            addr_q  <= bus.req_addr_i;
            len_q   <= bus.req_len_i;
            beat_q  <= '0;
            state_q <= HDR_ADDR;
          end
        end
        HDR_ADDR: begin
          if (bus.stream_ready_i) state_q <= HDR_LEN;
        end
        HDR_LEN: begin
          if (bus.stream_ready_i) state_q <= DAT_LO;
        end
        DAT_LO: begin
          if (bus.dat_valid_i && bus.stream_ready_i) begin
            hi_q    <= bus.dat_data_i[63:32];
            state_q <= DAT_HI;
          end
        end
        DAT_HI: begin
          if (bus.stream_ready_i) begin
            if (beat_q == len_q) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              frames_q <= frames_q + 16'h1;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= DAT_LO;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_dbb_wr_packer.sv
// Directed bench for the DBB write packer.
module tb_nvdla_dbb_wr_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        enable;
  logic        busy;
  logic        done;
  logic [15:0] frames;

  nvdla_dbb_wr_packer_if #(.ADDR_WIDTH(32), .LEN_WIDTH(4)) bus ();

  nvdla_dbb_wr_packer #(.ADDR_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clear),
    .enable_i (enable),
    .bus      (bus),
    .busy_o   (busy),
    .done_o   (done),
    .frames_o (frames)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] lo_w [16];
  logic [31:0] hi_w [16];
  logic [31:0] exp_w[40];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected frame: addr, len, then lo/hi of each beat
  task automatic build_exp(input logic [31:0] a, input int l);
    exp_w[0] = a;
    exp_w[1] = 32'(l);
    for (int i = 0; i <= l; i++) begin
      exp_w[2+2*i] = lo_w[i];
      exp_w[3+2*i] = hi_w[i];
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [3:0] l);
    int t;
    t = 0;
    bus.req_addr_i  = a;
    bus.req_len_i   = l;
    bus.req_valid_i = 1'b1;
    #1;
    while (!bus.req_ready_o && t < 50) begin
      tick();
      t++;
    end
    chk("req_accept", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  // Feed beats and consume words until done_o; checks every presented word
  // against the expected frame (so a held word must stay unchanged).
  task automatic drain(input bit toggle, output int words, output int drc);
    int beat;
    bit ph;
    bit seen;
    beat = 0; ph = 1'b1; seen = 1'b0; words = 0; drc = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      bus.stream_ready_i = toggle ? ph : 1'b1;
      ph = ~ph;
      bus.dat_valid_i = 1'b1;
      bus.dat_data_i  = {hi_w[beat % 16], lo_w[beat % 16]};
      #1;
      if (done) seen = 1'b1;
      else begin
        if (bus.stream_valid_o) begin
          chk("word", 64'(bus.stream_data_o), 64'(exp_w[words % 40]));
          chk("strb", 64'(bus.stream_strb_o), 64'hF);
          if (bus.stream_ready_i) words++;
        end
        if (bus.dat_ready_o) begin
          drc++;
          if (bus.dat_valid_i) beat++;
        end
        tick();
      end
    end
    chk("done_seen", 64'(seen), 64'h1);
    bus.dat_valid_i    = 1'b0;
    bus.stream_ready_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, b;
    for (int i = 0; i < 16; i++) begin
      lo_w[i] = 32'hA5A5_0000 + 32'(i);
      hi_w[i] = 32'h5A5A_0000 + 32'(i << 8);
    end

    // reset state, with every input trying to provoke activity
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h1000_0040; bus.req_len_i = 4'd0;
    bus.dat_valid_i = 1'b1; bus.dat_data_i = 64'h89AB_CDEF_0123_4567;
    bus.stream_ready_i = 1'b1;
    #2;
    chk("rst_req_ready",    64'(bus.req_ready_o),    64'h0);
    chk("rst_dat_ready",    64'(bus.dat_ready_o),    64'h0);
    chk("rst_stream_valid", 64'(bus.stream_valid_o), 64'h0);
    chk("rst_stream_data",  64'(bus.stream_data_o),  64'h0);
    chk("rst_strb",         64'(bus.stream_strb_o),  64'h0);
    chk("rst_busy",         64'(busy),               64'h0);
    chk("rst_done",         64'(done),               64'h0);
    chk("rst_frames",       64'(frames),             64'h0);
    tick(); tick();
    rst = 1'b0;

    // single-beat burst, ready always high
    #1;
    chk("t1_req_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t1_addr_valid", 64'(bus.stream_valid_o), 64'h1);
    chk("t1_addr",       64'(bus.stream_data_o),  64'h1000_0040);
    chk("t1_addr_strb",  64'(bus.stream_strb_o),  64'hF);
    chk("t1_busy",       64'(busy),               64'h1);
    chk("t1_hdr_dready", 64'(bus.dat_ready_o),    64'h0);
    tick(); #1;
    chk("t1_len",        64'(bus.stream_data_o),  64'h0);
    chk("t1_len_valid",  64'(bus.stream_valid_o), 64'h1);
    tick(); #1;
    chk("t1_lo",         64'(bus.stream_data_o),  64'h0123_4567);
    chk("t1_lo_dready",  64'(bus.dat_ready_o),    64'h1);
    tick(); #1;
    chk("t1_hi",         64'(bus.stream_data_o),  64'h89AB_CDEF);
    chk("t1_hi_dready",  64'(bus.dat_ready_o),    64'h0);
    tick(); #1;
    chk("t1_done",       64'(done),               64'h1);
    chk("t1_frames",     64'(frames),             64'h1);
    chk("t1_idle_busy",  64'(busy),               64'h0);
    chk("t1_idle_valid", 64'(bus.stream_valid_o), 64'h0);
    chk("t1_idle_dready",64'(bus.dat_ready_o),    64'h0);
    tick(); #1;
    chk("t1_done_pulse", 64'(done),               64'h0);
    bus.dat_valid_i = 1'b0;
    tick();

    // len=3 with stream_ready toggling
    build_exp(32'h2000_0100, 3);
    accept(32'h2000_0100, 4'd3);
    drain(1'b1, w, d);
    chk("t2_words",  64'(w),      64'd10);
    chk("t2_dready", 64'(d),      64'd4);
    chk("t2_frames", 64'(frames), 64'h2);
    tick();

    // enable low blocks acceptance
    enable = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h3000_0000; bus.req_len_i = 4'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_blk_ready", 64'(bus.req_ready_o),    64'h0);
      chk("t3_blk_valid", 64'(bus.stream_valid_o), 64'h0);
      tick();
    end
    enable = 1'b1;
    #1;
    chk("t3_en_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t3_busy", 64'(busy),              64'h1);
    chk("t3_addr", 64'(bus.stream_data_o), 64'h3000_0000);
    build_exp(32'h3000_0000, 0);
    drain(1'b0, w, d);
    chk("t3_words",  64'(w),      64'd4);
    chk("t3_frames", 64'(frames), 64'h3);
    tick();

    // clear in DAT_HI of beat 2 of a len=3 burst
    accept(32'h4000_0000, 4'd3);
    bus.stream_ready_i = 1'b1; bus.dat_valid_i = 1'b1;
    b = 0;
    for (int c = 0; c < 7; c++) begin
      bus.dat_data_i = {hi_w[b], lo_w[b]};
      #1;
      if (bus.dat_ready_o) b++;
      tick();
    end
    chk("t4_hi2", 64'(bus.stream_data_o), 64'(hi_w[2]));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.dat_valid_i = 1'b0;
    #1;
    chk("t4_clr_busy",   64'(busy),               64'h0);
    chk("t4_clr_frames", 64'(frames),             64'h0);
    chk("t4_clr_done",   64'(done),               64'h0);
    chk("t4_clr_valid",  64'(bus.stream_valid_o), 64'h0);
    tick();
    chk("t4_clr_done2",  64'(done),               64'h0);
    build_exp(32'h4400_0000, 0);
    accept(32'h4400_0000, 4'd0);
    drain(1'b0, w, d);
    chk("t4_words",  64'(w),      64'd4);
    chk("t4_frames", 64'(frames), 64'h1);
    tick();

    // async reset in DAT_LO
    accept(32'h6000_0000, 4'd1);
    bus.stream_ready_i = 1'b1; bus.dat_valid_i = 1'b1;
    bus.dat_data_i = {hi_w[0], lo_w[0]};
    tick(); tick();
    bus.req_valid_i = 1'b1;
    #1;
    chk("t6_in_dat_lo", 64'(bus.dat_ready_o), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_req_ready",    64'(bus.req_ready_o),    64'h0);
    chk("t6_dat_ready",    64'(bus.dat_ready_o),    64'h0);
    chk("t6_stream_valid", 64'(bus.stream_valid_o), 64'h0);
    chk("t6_stream_data",  64'(bus.stream_data_o),  64'h0);
    chk("t6_strb",         64'(bus.stream_strb_o),  64'h0);
    chk("t6_busy",         64'(busy),               64'h0);
    chk("t6_frames",       64'(frames),             64'h0);
    tick(); tick();
    rst = 1'b0;
    bus.req_valid_i = 1'b0; bus.dat_valid_i = 1'b0;
    tick();
    build_exp(32'h6600_0000, 1);
    accept(32'h6600_0000, 4'd1);
    drain(1'b0, w, d);
    chk("t6_words",  64'(w),      64'd6);
    chk("t6_frames", 64'(frames), 64'h1);
    tick();

    // maximum length: 16 beats, 34 words
    build_exp(32'h7000_0000, 15);
    accept(32'h7000_0000, 4'd15);
    drain(1'b0, w, d);
    chk("t7_words",  64'(w),      64'd34);
    chk("t7_dready", 64'(d),      64'd16);
    chk("t7_frames", 64'(frames), 64'h2);
    tick();

    // frame counter wrap from 0xFFFF
    force dut.frames_q = 16'hFFFF;
    tick();
    release dut.frames_q;
    #1;
    chk("t5_preload", 64'(frames), 64'hFFFF);
    build_exp(32'h5000_0000, 0);
    accept(32'h5000_0000, 4'd0);
    drain(1'b0, w, d);
    chk("t5_words", 64'(w),      64'd4);
    chk("t5_wrap",  64'(frames), 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
